// File: rtl/lc3_regfile_sb.sv
// ---------------------------------------------------------------------------
// lc3_regfile_sb
//
// Eight-entry 16-bit LC-3 general register file with a per-register
// pending-write scoreboard and the NZP condition codes.
//
// Decode reads SR1/SR2 combinationally and is told through STALL whether
// every operand it uses is ready. Decode reserves a destination with RSV at
// issue time, and writeback retires it with WE. Each register has a counter
// of in-flight writes that saturates at 2^CNT_W-1. Overflow, and underflow
// (a write with nothing reserved), set the sticky SB_ERR flag.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   SR1, SR2           source register indices
//   SR1_USE, SR2_USE   decode needs that operand this cycle
//   SR1_OUT, SR2_OUT   combinational read data
//   STALL              a used operand is not ready
//   RSV, RSV_DR        reserve destination at issue (honoured only if !STALL)
//   WE, WB_DR, WB_DATA writeback strobe, destination and value
//   LD_CC              also update CC from WB_DATA (qualified by WE)
//   CC                 {N,Z,P}
//   SB_ERR             sticky scoreboard overflow/underflow flag
//
// Configuration macro: LC3_RF_BYPASS_EN
//   When defined, a same-cycle writeback is forwarded to the read ports.
//   It also releases a stall on its last outstanding write in that cycle.
// ---------------------------------------------------------------------------
module lc3_regfile_sb #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  SR1,
  input  logic [2:0]  SR2,
  input  logic        SR1_USE,
  input  logic        SR2_USE,
  output logic [15:0] SR1_OUT,
  output logic [15:0] SR2_OUT,
  output logic        STALL,
  input  logic        RSV,
  input  logic [2:0]  RSV_DR,
  input  logic        WE,
  input  logic [2:0]  WB_DR,
  input  logic [15:0] WB_DATA,
  input  logic        LD_CC,
  output logic [2:0]  CC,
  output logic        SB_ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [15:0]      regs_q [8];
  logic [15:0]      regs_d [8];
  logic [CNT_W-1:0] cnt_q  [8];
  logic [CNT_W-1:0] cnt_d  [8];
  logic [2:0]       cc_q, cc_d;
  logic             sb_err_q, sb_err_d;

  logic             sr1_rdy, sr2_rdy;
  logic             rsv_ok;
  logic [7:0]       inc_vec, dec_vec;

  // -------------------------------------------------------------------------
  // Read ports and operand readiness
  // -------------------------------------------------------------------------
`ifdef LC3_RF_BYPASS_EN
  logic fwd1, fwd2;

  always_comb begin
    fwd1    = WE && (WB_DR == SR1);
    fwd2    = WE && (WB_DR == SR2);
    SR1_OUT = fwd1 ? WB_DATA : regs_q[SR1];
    SR2_OUT = fwd2 ? WB_DATA : regs_q[SR2];
    // The writeback in flight this cycle retires the last pending write.
    sr1_rdy = (cnt_q[SR1] == '0) || (fwd1 && (cnt_q[SR1] == CNT_ONE));
    sr2_rdy = (cnt_q[SR2] == '0) || (fwd2 && (cnt_q[SR2] == CNT_ONE));
  end
`else
  always_comb begin
    SR1_OUT = regs_q[SR1];
    SR2_OUT = regs_q[SR2];
    sr1_rdy = (cnt_q[SR1] == '0);
    sr2_rdy = (cnt_q[SR2] == '0);
  end
`endif

  assign STALL  = (SR1_USE && !sr1_rdy) || (SR2_USE && !sr2_rdy);
  // A reservation during a stall is dropped. Decode holds the instruction and retries.
  assign rsv_ok = RSV && !STALL;

  assign inc_vec = rsv_ok ? (8'b1 << RSV_DR) : 8'b0;
  assign dec_vec = WE     ? (8'b1 << WB_DR)  : 8'b0;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every _d variable takes its hold value first. Any path that skips an
  // assignment then keeps the old state instead of inferring a latch.
  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    cc_d     = cc_q;
    sb_err_d = sb_err_q;

    for (int r = 0; r < 8; r++) begin
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;        // overflow: drop it
        else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0)      sb_err_d = 1'b1;        // underflow: still write
        else                     cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end

    // The data write does not depend on the scoreboard state.
    if (WE) begin
      regs_d[WB_DR] = WB_DATA;
      if (LD_CC)
        cc_d = {WB_DATA[15], (WB_DATA == 16'h0000),
                !WB_DATA[15] && (WB_DATA != 16'h0000)};
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: the register array is reset too. Software expects R0..R7 to be zero
  // after reset. The array is only eight words, so this stays flops and
  // never maps to a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      cc_q     <= 3'b010;
      sb_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates, so every register samples pre-edge values.
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      cc_q     <= cc_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign CC     = cc_q;
  assign SB_ERR = sb_err_q;

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// ---------------------------------------------------------------------------
// Self-checking bench for lc3_regfile_sb. It runs directed scenarios and then
// a randomized run. Expected values come from a behavioural model that holds
// plain arrays of register values and in-flight write counts. Build with
// LC3_RF_BYPASS_EN to match the RTL configuration.
// ---------------------------------------------------------------------------
module tb_lc3_regfile_sb;

  localparam int CNT_MAX = 3;
`ifdef LC3_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  SR1, SR2, RSV_DR, WB_DR;
  logic        SR1_USE, SR2_USE, RSV, WE, LD_CC;
  logic [15:0] WB_DATA;
  logic [15:0] SR1_OUT, SR2_OUT;
  logic        STALL, SB_ERR;
  logic [2:0]  CC;

  int errors = 0;
  int checks = 0;

  lc3_regfile_sb #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .SR1(SR1), .SR2(SR2), .SR1_USE(SR1_USE), .SR2_USE(SR2_USE),
    .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .STALL(STALL),
    .RSV(RSV), .RSV_DR(RSV_DR),
    .WE(WE), .WB_DR(WB_DR), .WB_DATA(WB_DATA), .LD_CC(LD_CC),
    .CC(CC), .SB_ERR(SB_ERR)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_reg [8];
  int          m_cnt [8];
  logic [2:0]  m_cc;
  logic        m_err;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = 16'h0000;
      m_cnt[i] = 0;
    end
    m_cc  = 3'b010;
    m_err = 1'b0;
  endtask

  function automatic bit m_fwd(input logic [2:0] idx);
    return BYP && WE && (WB_DR == idx);
  endfunction

  function automatic bit m_rdy(input logic [2:0] idx);
    return (m_cnt[idx] == 0) || (m_fwd(idx) && m_cnt[idx] == 1);
  endfunction

  function automatic bit m_stall();
    return (SR1_USE && !m_rdy(SR1)) || (SR2_USE && !m_rdy(SR2));
  endfunction

  function automatic logic [15:0] m_out(input logic [2:0] idx);
    return m_fwd(idx) ? WB_DATA : m_reg[idx];
  endfunction

  task automatic model_edge();
    bit take;
    bit inc, dec;
    take = RSV && !m_stall();
    for (int r = 0; r < 8; r++) begin
      inc = take && (RSV_DR == r);
      dec = WE && (WB_DR == r);
      if (inc && !dec) begin
        if (m_cnt[r] == CNT_MAX) m_err = 1'b1;
        else m_cnt[r] = m_cnt[r] + 1;
      end else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_err = 1'b1;
        else m_cnt[r] = m_cnt[r] - 1;
      end
    end
    if (WE) begin
      m_reg[WB_DR] = WB_DATA;
      if (LD_CC)
        m_cc = ($signed(WB_DATA) < 0) ? 3'b100 : (WB_DATA == 0) ? 3'b010 : 3'b001;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    SR1 = 0; SR2 = 0; SR1_USE = 0; SR2_USE = 0;
    RSV = 0; RSV_DR = 0; WE = 0; WB_DR = 0; WB_DATA = 0; LD_CC = 0;
  endtask

  // Advance one clock: the model takes the edge, then control returns at the
  // following falling edge, where new inputs are driven.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    SR1_USE = 1; SR2_USE = 1; SR1 = 7; SR2 = 3;
    #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", STALL); end
    checks++; if (CC !== 3'b010) begin errors++; $display("FAIL reset_cc: got %b expected 010", CC); end
    checks++; if (SR1_OUT !== 16'h0000) begin errors++; $display("FAIL reset_sr1: got %h expected 0000", SR1_OUT); end

    // Write R3 and reserve R1, then reset asynchronously in the middle of a cycle.
    idle();
    WE = 1; WB_DR = 3; WB_DATA = 16'h0BAD; LD_CC = 1; RSV = 1; RSV_DR = 1;
    tick();
    idle();
    SR1 = 3; SR2 = 1; SR2_USE = 1;
    #1;
    checks++; if (SR1_OUT !== 16'h0BAD) begin errors++; $display("FAIL pre_reset_r3: got %h expected 0bad", SR1_OUT); end
    checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b expected 1", STALL); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (SR1_OUT !== 16'h0000) begin errors++; $display("FAIL async_reset_sr1: got %h expected 0000", SR1_OUT); end
    checks++; if (CC !== 3'b010) begin errors++; $display("FAIL async_reset_cc: got %b expected 010", CC); end
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL async_reset_stall: got %b expected 0", STALL); end
    checks++; if (SB_ERR !== 1'b0) begin errors++; $display("FAIL async_reset_err: got %b expected 0", SB_ERR); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    idle();
    WE = 1; WB_DR = 5; WB_DATA = 16'h8001; LD_CC = 1;
    tick();
    idle();
    SR1 = 5;
    #1;
    checks++; if (SR1_OUT !== 16'h8001) begin errors++; $display("FAIL wr_r5: got %h expected 8001", SR1_OUT); end
    checks++; if (CC !== 3'b100) begin errors++; $display("FAIL wr_cc_n: got %b expected 100", CC); end
    idle();
    WE = 1; WB_DR = 5; WB_DATA = 16'h0000; LD_CC = 1;
    tick();
    idle();
    SR2 = 5;
    #1;
    checks++; if (CC !== 3'b010) begin errors++; $display("FAIL wr_cc_z: got %b expected 010", CC); end
    checks++; if (SR2_OUT !== 16'h0000) begin errors++; $display("FAIL wr_r5_zero: got %h expected 0000", SR2_OUT); end
    // Positive value sets P. A following LD_CC without WE must change nothing.
    idle();
    WE = 1; WB_DR = 0; WB_DATA = 16'h7FFF; LD_CC = 1;
    tick();
    idle();
    LD_CC = 1; WB_DATA = 16'h8000; WB_DR = 0;
    tick();
    idle();
    #1;
    checks++; if (CC !== 3'b001) begin errors++; $display("FAIL wr_cc_p: got %b expected 001", CC); end
    checks++; if (SR1_OUT !== 16'h7FFF) begin errors++; $display("FAIL wr_r0: got %h expected 7fff", SR1_OUT); end
  endtask

  task automatic test_hazard();
    idle();
    RSV = 1; RSV_DR = 2;
    tick();
    idle();
    SR1 = 2; SR1_USE = 1;
    #1;
    checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL hz_stall: got %b expected 1", STALL); end
    RSV = 1; RSV_DR = 2;     // must be ignored while stalled
    tick();
    RSV = 0;
    WE = 1; WB_DR = 2; WB_DATA = 16'h1234;
    #1;
    checks++; if (STALL !== !BYP) begin errors++; $display("FAIL hz_wb_stall: got %b expected %b", STALL, !BYP); end
    if (BYP) begin
      checks++; if (SR1_OUT !== 16'h1234) begin errors++; $display("FAIL hz_fwd: got %h expected 1234", SR1_OUT); end
    end
    tick();
    WE = 0;
    #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL hz_after_stall: got %b expected 0", STALL); end
    checks++; if (SR1_OUT !== 16'h1234) begin errors++; $display("FAIL hz_after_data: got %h expected 1234", SR1_OUT); end
  endtask

  task automatic test_simultaneous();
    idle();
    RSV = 1; RSV_DR = 4;
    tick();
    RSV = 1; RSV_DR = 4; WE = 1; WB_DR = 4; WB_DATA = 16'h4444;
    tick();
    idle();
    SR2 = 4; SR2_USE = 1;
    #1;
    checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL sim_stall: got %b expected 1", STALL); end
    checks++; if (SR2_OUT !== 16'h4444) begin errors++; $display("FAIL sim_data: got %h expected 4444", SR2_OUT); end
    WE = 1; WB_DR = 4; WB_DATA = 16'h4445;
    tick();
    WE = 0;
    #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL sim_release: got %b expected 0", STALL); end
  endtask

  task automatic test_underflow();
    idle();
    WE = 1; WB_DR = 6; WB_DATA = 16'h6666;
    tick();
    idle();
    SR1 = 6; SR1_USE = 1;
    #1;
    checks++; if (SB_ERR !== 1'b1) begin errors++; $display("FAIL uf_err: got %b expected 1", SB_ERR); end
    checks++; if (SR1_OUT !== 16'h6666) begin errors++; $display("FAIL uf_data: got %h expected 6666", SR1_OUT); end
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL uf_stall: got %b expected 0", STALL); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      idle();
      RSV = 1; RSV_DR = 7;
      tick();
      idle();
      #1;
      checks++;
      if (SB_ERR !== (k == 4)) begin errors++; $display("FAIL sat_err_%0d: got %b expected %b", k, SB_ERR, k == 4); end
    end
    for (int k = 1; k <= 3; k++) begin
      idle();
      SR1 = 7; SR1_USE = 1;
      #1;
      checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL sat_stall_%0d: got %b expected 1", k, STALL); end
      WE = 1; WB_DR = 7; WB_DATA = 16'(16'h7000 + k);
      tick();
    end
    idle();
    SR1 = 7; SR1_USE = 1;
    #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b expected 0", STALL); end
    checks++; if (SR1_OUT !== 16'h7003) begin errors++; $display("FAIL sat_data: got %h expected 7003", SR1_OUT); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      SR1     = 3'($urandom_range(0, 7));
      SR2     = 3'($urandom_range(0, 7));
      SR1_USE = 1'($urandom_range(0, 1));
      SR2_USE = 1'($urandom_range(0, 1));
      RSV     = ($urandom_range(0, 9) < 4);
      RSV_DR  = 3'($urandom_range(0, 7));
      WE      = ($urandom_range(0, 9) < 4);
      WB_DR   = 3'($urandom_range(0, 7));
      WB_DATA = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      LD_CC   = 1'($urandom_range(0, 1));
      #1;
      checks++; if (SR1_OUT !== m_out(SR1)) begin errors++; $display("FAIL rnd_sr1 @%0d: got %h expected %h", n, SR1_OUT, m_out(SR1)); end
      checks++; if (SR2_OUT !== m_out(SR2)) begin errors++; $display("FAIL rnd_sr2 @%0d: got %h expected %h", n, SR2_OUT, m_out(SR2)); end
      checks++; if (STALL !== m_stall()) begin errors++; $display("FAIL rnd_stall @%0d: got %b expected %b", n, STALL, m_stall()); end
      checks++; if (CC !== m_cc) begin errors++; $display("FAIL rnd_cc @%0d: got %b expected %b", n, CC, m_cc); end
      checks++; if (SB_ERR !== m_err) begin errors++; $display("FAIL rnd_err @%0d: got %b expected %b", n, SB_ERR, m_err); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hazard();
    test_simultaneous();
    test_underflow();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_regfile_sb.md
Name: lc3_regfile_sb

Overview:
- Eight-entry 16-bit LC-3 general register file with a per-register pending-write scoreboard.
- It is the read side of the pipeline's register writes. Decode reads SR1/SR2 through it and is told whether the operands are valid.
- Writeback retires destination writes into it.
- It also holds the NZP condition codes.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter. Up to 2^CNT_W-1 writes can be in flight per register.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- SR1  input  3  source register 1 index
- SR2  input  3  source register 2 index
- SR1_USE  input  1  decode needs SR1 this cycle
- SR2_USE  input  1  decode needs SR2 this cycle
- SR1_OUT  output  16  register data for SR1 (combinational read)
- SR2_OUT  output  16  register data for SR2 (combinational read)
- STALL  output  1  a used source operand is not ready
- RSV  input  1  decode issues an instruction that will write RSV_DR
- RSV_DR  input  3  destination reserved at issue
- WE  input  1  writeback strobe
- WB_DR  input  3  writeback destination
- WB_DATA  input  16  writeback value
- LD_CC  input  1  update condition codes from WB_DATA (qualified by WE)
- CC  output  3  {N,Z,P} condition codes
- SB_ERR  output  1  sticky scoreboard error flag

Behaviour:
- Reset (asynchronous, rst=1) clears all of the following immediately:
  - R0..R7 = 16'h0000.
  - All pending counters = 0.
  - CC = 3'b010 (Z).
  - SB_ERR = 0.
  - Resulting outputs: STALL=0 and SR1_OUT = SR2_OUT = 0.
- Reset mid-operation discards every reservation and any same-edge write.
- Reads are combinational, zero latency: SRn_OUT = R[SRn], subject to the bypass rule in Optional Feature.
- Ready rule: SRn_RDY = (cnt[SRn]==0), or bypass-ready as defined in Optional Feature.
- STALL = (SR1_USE & ~SR1_RDY) | (SR2_USE & ~SR2_RDY). Combinational.
- Reservation handshake:
  - RSV is honoured only when STALL=0.
  - RSV while STALL=1 is ignored, with no counter change. Decode must hold the instruction and retry.
- Counter update per register r at each rising edge:
  - inc = RSV & ~STALL & (RSV_DR==r); dec = WE & (WB_DR==r).
  - inc & dec: count unchanged.
  - inc only: count+1. If count is already at max (2^CNT_W-1), the count saturates, the reservation is dropped and SB_ERR is set.
  - dec only: count-1. If count is already 0, the count stays 0, the write is still performed and SB_ERR is set.
- Data write: WE=1 writes R[WB_DR] <= WB_DATA at the edge. The write is unconditional on the scoreboard state.
- CC update: on WE & LD_CC at the edge:
  - N = WB_DATA[15].
  - Z = (WB_DATA==0).
  - P = ~N & ~Z.
  - Exactly one bit of CC is set at all times.
- WE=0 means no register or CC change. LD_CC without WE is ignored.
- SB_ERR is sticky until rst.
- R0 is a normal register (LC-3 has no hardwired zero).
- Simultaneous RSV and WE to different registers are fully independent.

Optional Feature:
- Macro: LC3_RF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if WE & (WB_DR==SRn) in the same cycle, SRn_OUT = WB_DATA.
  - SRn_RDY also asserts when cnt[SRn]==1 and WE & (WB_DR==SRn), so the last outstanding write resolves the stall in the writeback cycle.
- Not defined:
  - No forwarding: SRn_OUT always shows the stored value.
  - Ready strictly requires cnt==0, so a consumer stalls one cycle longer and reads the new value the cycle after writeback.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with R3 previously written -> SR1_OUT=0 immediately, CC=3'b010, STALL=0, SB_ERR=0.
- Basic write/read: WE, WB_DR=5, WB_DATA=16'h8001, LD_CC=1 -> next cycle SR1=5 gives SR1_OUT=16'h8001 and CC=3'b100. Then write 16'h0000 with LD_CC -> CC=3'b010.
- Hazard:
  - RSV, RSV_DR=2, then SR1=2 with SR1_USE=1 -> STALL=1.
  - A RSV asserted during the stall leaves all counters unchanged.
  - WE to R2 with 16'h1234: with BYPASS_EN, STALL=0 and SR1_OUT=16'h1234 in that same cycle. Without it, STALL=0 and SR1_OUT=16'h1234 one cycle later.
- Simultaneous: RSV_DR=4 and WE WB_DR=4 on the same edge with cnt[4]=1 -> cnt stays 1, STALL remains 1 for SR2=4 with SR2_USE=1.
- Saturation: 4 RSV to R7 with CNT_W=2 -> after the 4th, SB_ERR=1 and cnt=3. Three WE to R7 -> STALL clears.
- Underflow: WE to R6 with cnt=0 -> R6 updated, SB_ERR=1, cnt stays 0.
